div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Sequential multi-cycle divide controller for the 32-bit CPU datapath; it replaces the single-cycle combinational divider for DIV.
- Latches operands on a start pulse and runs a restoring division, one quotient bit per clock, over 32 iterations.
- Applies signed pre- and post-correction, flags divide-by-zero, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse.
- The control unit holds the instruction while busy is high.

Parameters:
- WIDTH, 32, operand, quotient and remainder width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  asynchronous active-high reset
- start  input  1  request a divide; sampled only in IDLE
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned
- dividend  input  WIDTH  numerator, captured when start is accepted
- divisor  input  WIDTH  denominator, captured when start is accepted
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; quotient and remainder are valid from this cycle
- quotient  output  WIDTH  result to LO
- remainder  output  WIDTH  result to HI
- div_by_zero  output  1  set with done when divisor == 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is clr, asynchronous and active-high.
- While clr is high: state = IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; all internal registers cleared.
- clr mid-operation aborts immediately. No done pulse is issued and no partial result is kept.
- States and transitions:
  - IDLE → PREP when start = 1. Operands and signed_op are latched here. Later input changes have no effect.
  - PREP: computes |dividend| and |divisor| when signed_op = 1 (raw values otherwise), sign_q = sign(dividend) ^ sign(divisor), sign_r = sign(dividend). Sets A = 0, Q = magnitude of dividend, count = 0.
    - If divisor == 0: go to DONE_ST.
    - Otherwise: go to ITER.
  - ITER, one cycle per step, 32 steps:
    - {A,Q} shifts left one bit.
    - T = {1'b0,A} − {1'b0,M} is computed in WIDTH+1 bits so that unsigned divisors ≥ 2^31 are handled correctly.
    - If T[WIDTH] = 1: Q[0] = 0 and A is unchanged (restore).
    - Otherwise: Q[0] = 1 and A = T[WIDTH−1:0].
    - count increments; after step 32, go to FIXUP.
  - FIXUP: quotient = sign_q ? −Q : Q; remainder = sign_r ? −A : A, both only when signed_op = 1. Go to DONE_ST.
  - DONE_ST: done = 1 for exactly this cycle, busy = 0. Go to IDLE.
- busy is high in PREP, ITER and FIXUP.
- Latency: start sampled at edge 0 gives done high in cycle 35 (PREP 1, ITER 32, FIXUP 1). Divide-by-zero gives done in cycle 2.
- Divide-by-zero result: quotient = all ones, remainder = raw latched dividend, div_by_zero = 1.
- div_by_zero clears on the next accepted start.
- Signed overflow (−2^31 / −1): quotient = 0x80000000 (wraps), remainder = 0, no flag.
- start while busy is ignored, with no queueing.
- start in the DONE_ST cycle is ignored. start in the following IDLE cycle is accepted.
- quotient and remainder hold their last values after done until the next FIXUP or DONE_ST update, or until clr.

Decomposition:
- Shared package, div_pkg:
  - state enum {IDLE, PREP, ITER, FIXUP, DONE_ST}
  - DIV_WIDTH = 32
  - DIV0_QUOT = all-ones constant
  - count width = $clog2(DIV_WIDTH)+1
- Sub-module div_step (combinational, one restoring iteration):
  - Inputs: A, Q, M. Outputs: A_next, Q_next.
  - Performs the shift, the WIDTH+1-bit subtract and the restore select.
  - Instantiated once; the controller registers its outputs each ITER cycle.

Test Plan:
- Unsigned 100 / 7, start pulse at cycle 0 → busy cycles 1–34, done in cycle 35 only, quotient = 14, remainder = 2, div_by_zero = 0.
- Signed −7 / 2 → quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1). Also signed 7 / −2 → quotient = −3, remainder = 1.
- Unsigned 0xFFFFFFFF / 0x80000000 → quotient = 1, remainder = 0x7FFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0.
- 5 / 0 (either mode) → done in cycle 2, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1. The next valid start clears div_by_zero.
- Start 100 / 7, then change dividend to 50 and pulse start again at cycle 10 → ignored; result is still 14 r 2 at cycle 35.
- Start a divide, assert clr asynchronously at cycle 10 → busy, done and outputs are 0 immediately and no done pulse follows. After release, 9 / 3 gives quotient = 3, remainder = 0 in 35 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE_ST
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {a,q} left, trial-subtract m, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] q_next
);

    // The shifted remainder needs WIDTH+1 bits, otherwise divisors >= 2^(WIDTH-1) lose the carried-out bit.
    logic [WIDTH:0] a_shift;
    logic [WIDTH:0] diff;

    assign a_shift = {a, q[WIDTH-1]};
    assign diff    = a_shift - {1'b0, m};
    assign a_next  = diff[WIDTH] ? a_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divide controller: one quotient bit per clock, LO = quotient, HI = remainder.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic             signed_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_m;
    logic             sign_q;
    logic             sign_r;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0] mag_dvs;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] quo_next;

    // Magnitudes only differ from the raw operands for negative values in signed mode.
    assign mag_dvd = (signed_r && dividend_r[WIDTH-1]) ? -dividend_r : dividend_r;
    assign mag_dvs = (signed_r && divisor_r[WIDTH-1])  ? -divisor_r  : divisor_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (acc),
        .q      (quo),
        .m      (mag_m),
        .a_next (acc_next),
        .q_next (quo_next)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            dividend_r  <= '0;
            divisor_r   <= '0;
            signed_r    <= 1'b0;
            acc         <= '0;
            quo         <= '0;
            mag_m       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dividend_r  <= dividend;
                        divisor_r   <= divisor;
                        signed_r    <= signed_op;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    acc    <= '0;
                    quo    <= mag_dvd;
                    mag_m  <= mag_dvs;
                    count  <= '0;
                    sign_q <= signed_r & (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
                    sign_r <= signed_r & dividend_r[WIDTH-1];
                    if (divisor_r == '0) begin
                        quotient    <= DIV0_QUOT;
                        remainder   <= dividend_r;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE_ST;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    acc   <= acc_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    quotient  <= sign_q ? -quo : quo;
                    remainder <= sign_r ? -acc : acc;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE_ST;
                end
                DONE_ST: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed, table-driven bench for div_seq_ctrl plus hand-written multi-cycle corner sequences.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    div_seq_ctrl dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drives operands with a one-cycle start pulse; returns #1 after the accepting edge (cycle 1).
    task automatic applyStimulus(input logic sop, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        signed_op = ~sop;
        dividend  = ~a;
        divisor   = ~b;
    endtask

    task automatic runVector(input int idx, input vec_t v);
        int          done_cyc;
        int          done_cnt;
        int          busy_bad;
        logic [31:0] q_done;
        logic [31:0] r_done;
        logic        dz_done;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        q_done   = 'x;
        r_done   = 'x;
        dz_done  = 1'bx;
        applyStimulus(v.sop, v.a, v.b);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy !== ((c < v.exp_lat) ? 1'b1 : 1'b0)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    q_done   = quotient;
                    r_done   = remainder;
                    dz_done  = div_by_zero;
                end
            end
        end
        checkOutput("done_cycle", idx, done_cyc, v.exp_lat);
        checkOutput("done_pulses", idx, done_cnt, 1);
        checkOutput("busy_window_errors", idx, busy_bad, 0);
        checkOutput("quotient", idx, q_done, v.exp_q);
        checkOutput("remainder", idx, r_done, v.exp_r);
        checkOutput("div_by_zero", idx, {31'b0, dz_done}, {31'b0, v.exp_dz});
        checkOutput("quotient_hold", idx, quotient, v.exp_q);
        checkOutput("remainder_hold", idx, remainder, v.exp_r);
    endtask

    initial begin
        int          done_cyc;
        int          done_cnt;
        logic [31:0] q_done;
        logic [31:0] r_done;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 35};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 35};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 35};
        vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 35};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        vecs[6]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 2};
        vecs[8]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 35};
        vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 35};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 35};

        clr       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        checkOutput("reset_busy", 0, {31'b0, busy}, 32'd0);
        checkOutput("reset_done", 0, {31'b0, done}, 32'd0);
        checkOutput("reset_quotient", 0, quotient, 32'd0);
        checkOutput("reset_remainder", 0, remainder, 32'd0);
        checkOutput("reset_div_by_zero", 0, {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 11; i++) begin
            runVector(i, vecs[i]);
        end

        // A second start while busy (with a new dividend) must not disturb the running 100 / 7.
        done_cyc = -1;
        done_cnt = 0;
        q_done   = 'x;
        r_done   = 'x;
        applyStimulus(1'b0, 32'd100, 32'd7);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) begin
                dividend = 32'd50;
                divisor  = 32'd7;
                start    = 1'b1;
            end
            if (c == 11) start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    q_done   = quotient;
                    r_done   = remainder;
                end
            end
        end
        checkOutput("busy_start_done_cycle", 0, done_cyc, 35);
        checkOutput("busy_start_done_pulses", 0, done_cnt, 1);
        checkOutput("busy_start_quotient", 0, q_done, 32'd14);
        checkOutput("busy_start_remainder", 0, r_done, 32'd2);

        // Start raised during DONE_ST is ignored; held into the next IDLE cycle it is accepted.
        done_cyc = -1;
        done_cnt = 0;
        q_done   = 'x;
        r_done   = 'x;
        applyStimulus(1'b0, 32'd30, 32'd4);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 35) begin
                checkOutput("first_done_at_35", 0, {31'b0, done}, 32'd1);
                checkOutput("first_quotient", 0, quotient, 32'd7);
                checkOutput("first_remainder", 0, remainder, 32'd2);
                signed_op = 1'b0;
                dividend  = 32'd20;
                divisor   = 32'd4;
                start     = 1'b1;
            end
            if (c == 36) checkOutput("done_st_start_ignored", 0, {31'b0, busy}, 32'd0);
            if (c == 37) begin
                checkOutput("idle_start_accepted", 0, {31'b0, busy}, 32'd1);
                start = 1'b0;
            end
            if (c > 35 && done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    q_done   = quotient;
                    r_done   = remainder;
                end
            end
        end
        checkOutput("back_to_back_done_cycle", 0, done_cyc, 71);
        checkOutput("back_to_back_done_pulses", 0, done_cnt, 1);
        checkOutput("back_to_back_quotient", 0, q_done, 32'd5);
        checkOutput("back_to_back_remainder", 0, r_done, 32'd0);

        // Asynchronous clear mid-divide must zero outputs at once and suppress any done pulse.
        applyStimulus(1'b1, 32'hFFFF_FFD8, 32'd6);
        repeat (9) @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        checkOutput("clr_busy", 0, {31'b0, busy}, 32'd0);
        checkOutput("clr_done", 0, {31'b0, done}, 32'd0);
        checkOutput("clr_quotient", 0, quotient, 32'd0);
        checkOutput("clr_remainder", 0, remainder, 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        checkOutput("clr_no_activity", 0, done_cnt, 0);
        runVector(11, vecs[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
